uart_host_bridge: RTL and testbench
===================================

# uart_host_bridge

- Bus initiator that owns the memory-mapped `uart` peripheral.
- After reset it programs the receive control, transmit control and interrupt enable registers.
- It then moves bytes between two valid/ready byte streams and the UART's txdata/rxdata registers, using the peripheral's rd_en/wr_en/addr/busy handshake.
- It sits between the UART and any byte-oriented client (loader, debug monitor), so the client never sees the register map.

## Interface
- NSTOP, 1, written to txctrl[1]; 1 selects two stop bits.
- TX_WATERMARK, 1, 3-bit value written to txctrl[18:16].
- RX_WATERMARK, 0, 3-bit value written to rxctrl[18:16].
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- uart_rd_en  out  1  read request to the UART.
- uart_wr_en  out  1  write request to the UART.
- uart_addr  out  5  register byte address; bits [1:0] always 0.
- uart_wr_data  out  32  write data.
- uart_rd_data  in  32  read data / status from the UART.
- uart_busy  in  1  UART is processing the current request.
- tx_byte  in  8  byte to transmit.
- tx_valid  in  1  tx_byte is valid.
- tx_ready  out  1  bridge accepts tx_byte this cycle.
- rx_byte  out  8  received byte.
- rx_valid  out  1  rx_byte is valid.
- rx_ready  in  1  client consumes rx_byte this cycle.
- init_done  out  1  configuration sequence complete.

## Operation
- Register map, as uart_addr[4:2]:
  - 000 txdata: write [7:0]; returned [31] = full.
  - 001 rxdata: [31] = empty, [7:0] = data.
  - 010 txctrl.
  - 011 rxctrl.
  - 100 ie.
  - 101 ip: [0] = txwm, [1] = rxwm.
- State machine: CFG_RX -> CFG_TX -> CFG_IE -> IDLE; service states are POLL_IP (macro only), RD_RX and WR_TX, each returning to IDLE.
  - CFG_RX writes rxctrl = RX_WATERMARK<<16 | 1.
  - CFG_TX writes txctrl = TX_WATERMARK<<16 | NSTOP<<1 | 1.
  - CFG_IE writes ie = 3 with the macro, 0 without.
  - init_done rises on completion of the CFG_IE transaction and stays high until reset.
- TX holding register, one byte plus a full flag:
  - tx_ready = init_done & ~tx_hold_full & (state == IDLE).
  - tx_valid & tx_ready loads the byte into the holding register.
- WR_TX writes the held byte.
  - If the returned uart_rd_data[31] = 1, the UART was full and dropped the byte: the bridge keeps the byte and retries later.
  - If it is 0, the holding register is cleared.
- RD_RX is issued only when the rx holding register is empty (rx_valid = 0).
  - If returned [31] = 0: rx_byte <= [7:0] and rx_valid <= 1.
  - If [31] = 1: the result is discarded.
- rx_valid clears on rx_valid & rx_ready.
- Arbitration in IDLE: when both RD_RX and WR_TX are eligible, a round-robin bit alternates between them; it toggles after each completed service transaction.
- Reset at any time:
  - Outputs drop immediately.
  - Both holding registers empty; any in-flight UART transaction is abandoned.
  - The FSM restarts at CFG_RX.
- Reset values of all outputs are 0: uart_rd_en, uart_wr_en, uart_addr, uart_wr_data, tx_ready, rx_byte, rx_valid, init_done.

## Timing
- Transaction:
  - uart_addr, uart_wr_data and exactly one enable are driven from the cycle after entering the state.
  - They are held constant until completion.
- Completion is the first cycle with busy_q = 1 and uart_busy = 0, where busy_q is uart_busy registered.
  - uart_rd_data is sampled in that cycle.
  - Enables deassert on the next edge.
- There is at least one IDLE cycle with both enables low between consecutive transactions.
- There is no timeout: a UART that never asserts busy stalls the bridge until reset.
- The tx handshake completes in 1 cycle; rx_byte is stable while rx_valid is high.
- Best-case latency from tx_valid (in IDLE, UART not full) to the txdata write completing: 2 cycles plus the UART busy duration; one extra ip transaction with the macro.

## Configuration
- UART_HOST_IRQ_EN defined:
  - ie is written 3.
  - Every service round first reads ip (POLL_IP).
  - RD_RX is eligible only if ip[1] = 1; WR_TX only if ip[0] = 1 and a byte is held.
- UART_HOST_IRQ_EN undefined:
  - ie is written 0 and there is no POLL_IP state.
  - RD_RX is eligible whenever rx_valid = 0; WR_TX whenever a byte is held.
  - Emptiness and fullness are learned from bit 31 of the returned data.

## Test plan
- Reset release with a UART model asserting busy 3 cycles per request -> writes to addr 0x0C (data 0x1), 0x08 (data 0x10003), then 0x10; init_done = 1 after the third completion.
- tx_valid with tx_byte = 0xA5 after init -> exactly one write to 0x00 with wr_data[7:0] = 0xA5; tx_ready low until the write completes with [31] = 0.
- UART model returns full ([31] = 1) twice on txdata writes -> 0xA5 is rewritten on each try and the holding register clears only on the third, successful write.
- UART model returns rxdata 0x0000_003C with rx_ready = 0 for 20 cycles -> rx_byte = 0x3C, rx_valid high throughout, and no rxdata read issued until rx_ready is asserted.
- tx byte held and rx eligible simultaneously for 4 rounds -> service order alternates RD_RX, WR_TX, RD_RX, WR_TX.
- reset asserted mid-transaction while busy = 1 -> uart_rd_en, uart_wr_en and init_done are 0 in the same time step, and the bridge restarts with a write to 0x0C.

Source files
------------

// File: rtl/uart_host_bridge.sv
// Bus initiator for the memory-mapped uart: configures it after reset, then moves bytes between
// valid/ready streams and txdata/rxdata. Optional macro UART_HOST_IRQ_EN gates service on the ip register.
module uart_host_bridge #(
  parameter logic       NSTOP        = 1'b1,
  parameter logic [2:0] TX_WATERMARK = 3'd1,
  parameter logic [2:0] RX_WATERMARK = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        uart_rd_en,
  output logic        uart_wr_en,
  output logic [4:0]  uart_addr,
  output logic [31:0] uart_wr_data,
  input  logic [31:0] uart_rd_data,
  input  logic        uart_busy,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done
);

  localparam logic [4:0] A_TXDATA = 5'h00;
  localparam logic [4:0] A_RXDATA = 5'h04;
  localparam logic [4:0] A_TXCTRL = 5'h08;
  localparam logic [4:0] A_RXCTRL = 5'h0C;
  localparam logic [4:0] A_IE     = 5'h10;
`ifdef UART_HOST_IRQ_EN
  localparam logic [4:0]  A_IP    = 5'h14;
  localparam logic [31:0] IE_VAL  = 32'd3;
`else
  localparam logic [31:0] IE_VAL  = 32'd0;
`endif
  localparam logic [31:0] RXCTRL_VAL = {13'd0, RX_WATERMARK, 16'd1};
  localparam logic [31:0] TXCTRL_VAL = {13'd0, TX_WATERMARK, 14'd0, NSTOP, 1'b1};

  typedef enum logic [2:0] {
    CFG_RX, CFG_TX, CFG_IE, IDLE, RD_RX, WR_TX
`ifdef UART_HOST_IRQ_EN
    , POLL_IP
`endif
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } uart_req_t;

  state_t    state, state_nxt, svc_nxt;
  uart_req_t req;
  logic      req_on, busy_q, done, rr;
  logic      tx_full;
  logic [7:0] tx_hold;
  logic      rd_elig, wr_elig;
  logic      unused_rd_bits;

  assign unused_rd_bits = ^uart_rd_data[30:8];

  // Completion: the UART has been seen busy and has just dropped it.
  assign done = req_on & busy_q & ~uart_busy;

`ifdef UART_HOST_IRQ_EN
  logic [1:0] ip_q;
  logic       ip_fresh;
  assign rd_elig = ~rx_valid & ip_q[1];
  assign wr_elig = tx_full & ip_q[0];
`else
  assign rd_elig = ~rx_valid;
  assign wr_elig = tx_full;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CFG_RX;
    else       state <= state_nxt;
  end

  // Service pick: round-robin only matters when both sides want the bus.
  always_comb begin
    svc_nxt = IDLE;
    if (rd_elig && wr_elig) svc_nxt = rr ? WR_TX : RD_RX;
    else if (rd_elig)       svc_nxt = RD_RX;
    else if (wr_elig)       svc_nxt = WR_TX;
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      CFG_RX: if (done) state_nxt = CFG_TX;
      CFG_TX: if (done) state_nxt = CFG_IE;
      CFG_IE: if (done) state_nxt = IDLE;
      IDLE: begin
`ifdef UART_HOST_IRQ_EN
        if (!ip_fresh) state_nxt = POLL_IP;
        else           state_nxt = svc_nxt;
`else
        state_nxt = svc_nxt;
`endif
      end
`ifdef UART_HOST_IRQ_EN
      POLL_IP: if (done) state_nxt = IDLE;
`endif
      RD_RX, WR_TX: if (done) state_nxt = IDLE;
      default: state_nxt = CFG_RX;
    endcase
  end

  // Outputs: request fields come from the state, but only once req_on is up.
  always_comb begin
    req = '0;
    if (req_on) begin
      case (state)
        CFG_RX: req = '{rd: 1'b0, wr: 1'b1, addr: A_RXCTRL, data: RXCTRL_VAL};
        CFG_TX: req = '{rd: 1'b0, wr: 1'b1, addr: A_TXCTRL, data: TXCTRL_VAL};
        CFG_IE: req = '{rd: 1'b0, wr: 1'b1, addr: A_IE,     data: IE_VAL};
        RD_RX:  req = '{rd: 1'b1, wr: 1'b0, addr: A_RXDATA, data: 32'd0};
        WR_TX:  req = '{rd: 1'b0, wr: 1'b1, addr: A_TXDATA, data: {24'd0, tx_hold}};
`ifdef UART_HOST_IRQ_EN
        POLL_IP: req = '{rd: 1'b1, wr: 1'b0, addr: A_IP,    data: 32'd0};
`endif
        default: req = '0;
      endcase
    end
  end

  assign uart_rd_en   = req.rd;
  assign uart_wr_en   = req.wr;
  assign uart_addr    = req.addr;
  assign uart_wr_data = req.data;
  assign tx_ready     = init_done & ~tx_full & (state == IDLE);

  // First cycle of every transaction state keeps the enables low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_on <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      req_on <= (state_nxt == state) && (state != IDLE);
      busy_q <= uart_busy;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_done <= 1'b0;
      rr        <= 1'b0;
    end else begin
      if (state == CFG_IE && done) init_done <= 1'b1;
      if (done && (state == RD_RX || state == WR_TX)) rr <= ~rr;
    end
  end

  // TX holding register: a full UART leaves the byte in place for a retry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_full <= 1'b0;
      tx_hold <= 8'd0;
    end else if (tx_valid && tx_ready) begin
      tx_full <= 1'b1;
      tx_hold <= tx_byte;
    end else if (state == WR_TX && done && !uart_rd_data[31]) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
    end else if (state == RD_RX && done && !uart_rd_data[31]) begin
      rx_valid <= 1'b1;
      rx_byte  <= uart_rd_data[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef UART_HOST_IRQ_EN
  // ip snapshot is consumed by exactly one IDLE decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ip_q     <= 2'b00;
      ip_fresh <= 1'b0;
    end else if (state == POLL_IP && done) begin
      ip_q     <= uart_rd_data[1:0];
      ip_fresh <= 1'b1;
    end else if (state == IDLE) begin
      ip_fresh <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed scoreboard bench for uart_host_bridge against a behavioural UART register model.
module tb_uart_host_bridge;

  localparam int BUSY_CYC = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rd_en, uart_wr_en;
  logic [4:0]  uart_addr;
  logic [31:0] uart_wr_data;
  logic [31:0] uart_rd_data = 32'd0;
  logic        uart_busy = 1'b0;
  logic [7:0]  tx_byte = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        init_done;

  uart_host_bridge dut (
    .clock(clock), .reset(reset),
    .uart_rd_en(uart_rd_en), .uart_wr_en(uart_wr_en), .uart_addr(uart_addr),
    .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data), .uart_busy(uart_busy),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_obs[$], wr_exp[$];
  logic [7:0] rx_exp[$];
  int         svc_log[$];
  int         n_cmp = 0, n_err = 0;

  // UART model state
  int          busy_cnt = 0, full_cnt = 0, tx_ok_cnt = 0, rx_rd_cnt = 0;
  bit          served = 0, pend_ok = 0, rx_avail = 0;
  logic [7:0]  rx_data = 8'd0;
  logic [31:0] resp = 32'd0;

  // UART model: busy for BUSY_CYC cycles per request, response valid when busy drops.
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0; uart_busy = 1'b0; served = 0; pend_ok = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        uart_busy = 1'b0; uart_rd_data = resp; served = 1;
        if (pend_ok) tx_ok_cnt++;
        pend_ok = 0;
      end
    end else if (uart_rd_en || uart_wr_en) begin
      if (!served) begin
        uart_busy = 1'b1; busy_cnt = BUSY_CYC; resp = 32'd0;
        if (uart_wr_en) begin
          wr_obs.push_back('{addr: uart_addr, data: uart_wr_data});
          if (uart_addr == 5'h00) begin
            svc_log.push_back(1);
            if (full_cnt > 0) begin full_cnt--; resp = 32'h8000_0000; end
            else pend_ok = 1;
          end
        end else if (uart_addr == 5'h04) begin
          svc_log.push_back(0);
          rx_rd_cnt++;
          if (rx_avail) begin resp = {24'd0, rx_data}; rx_avail = 0; end
          else resp = 32'h8000_0000;
        end
      end
    end else begin
      served = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drain_writes(input string tag);
    wr_t e, o;
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      check({tag, "_present"}, 32'(wr_obs.size() > 0), 32'd1);
      if (wr_obs.size() > 0) begin
        o = wr_obs.pop_front();
        check({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
        check({tag, "_data"}, o.data, e.data);
      end
    end
    check({tag, "_no_extra"}, 32'(wr_obs.size()), 32'd0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    for (int i = 0; i < 300 && !tx_ready; i++) tick();
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_byte = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    int snap, bad, base;
    logic [7:0] rexp;

    // Reset state
    #1;
    check("rst_enables", {30'd0, uart_rd_en, uart_wr_en}, 32'd0);
    check("rst_addr", 32'(uart_addr), 32'd0);
    check("rst_wdata", uart_wr_data, 32'd0);
    check("rst_flags", {29'd0, tx_ready, rx_valid, init_done}, 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);

    // Configuration sequence
    wr_exp.push_back('{addr: 5'h0C, data: 32'h0000_0001});
    wr_exp.push_back('{addr: 5'h08, data: 32'h0001_0003});
    wr_exp.push_back('{addr: 5'h10, data: 32'h0000_0000});
    tick(); tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 200 && !init_done; i++) begin
      tick();
      if (init_done && wr_obs.size() < 3) bad++;
    end
    check("init_done", 32'(init_done), 32'd1);
    check("init_early", 32'(bad), 32'd0);
    drain_writes("cfg");

    // Single tx byte
    wr_exp.push_back('{addr: 5'h00, data: 32'h0000_00A5});
    send_tx(8'hA5);
    check("tx_ready_low", 32'(tx_ready), 32'd0);
    for (int i = 0; i < 300 && !tx_ready; i++) tick();
    check("tx_ready_back", 32'(tx_ready), 32'd1);
    check("tx_ok_at_ready", 32'(tx_ok_cnt), 32'd1);
    drain_writes("tx1");

    // UART full twice, then accepts
    full_cnt = 2;
    repeat (3) wr_exp.push_back('{addr: 5'h00, data: 32'h0000_00A5});
    send_tx(8'hA5);
    bad = 0;
    for (int i = 0; i < 1000 && tx_ok_cnt < 2; i++) begin
      if (tx_ready) bad++;
      tick();
    end
    check("tx_retry_ok", 32'(tx_ok_cnt), 32'd2);
    check("tx_ready_during_retry", 32'(bad), 32'd0);
    for (int i = 0; i < 20 && !tx_ready; i++) tick();
    check("tx_ready_after_retry", 32'(tx_ready), 32'd1);
    drain_writes("tx_retry");

    // Received byte held while the client stalls
    rx_ready = 1'b0;
    rx_data = 8'h3C; rx_exp.push_back(8'h3C); rx_avail = 1;
    for (int i = 0; i < 300 && !rx_valid; i++) tick();
    check("rx_valid", 32'(rx_valid), 32'd1);
    if (rx_exp.size() > 0) begin
      rexp = rx_exp.pop_front();
      check("rx_byte", 32'(rx_byte), 32'(rexp));
    end
    snap = rx_rd_cnt; bad = 0;
    repeat (20) begin
      tick();
      if (!rx_valid || rx_byte !== 8'h3C) bad++;
    end
    check("rx_stable", 32'(bad), 32'd0);
    check("rx_no_reads", 32'(rx_rd_cnt - snap), 32'd0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_consumed", 32'(rx_valid), 32'd0);
    for (int i = 0; i < 100 && rx_rd_cnt == snap; i++) tick();
    check("rx_reads_resume", 32'(rx_rd_cnt > snap), 32'd1);

    // Round robin with both sides eligible
    full_cnt = 4;
    base = tx_ok_cnt;
    send_tx(8'h5A);
    svc_log.delete();
    // The first service was picked before the byte was held; skip it.
    for (int i = 0; i < 100 && svc_log.size() < 1; i++) tick();
    svc_log.delete();
    for (int i = 0; i < 300 && svc_log.size() < 4; i++) tick();
    check("rr_rounds", 32'(svc_log.size() >= 4), 32'd1);
    if (svc_log.size() >= 4)
      for (int i = 1; i < 4; i++) check("rr_alternate", 32'(svc_log[i] != svc_log[i-1]), 32'd1);
    for (int i = 0; i < 2000 && tx_ok_cnt == base; i++) tick();
    check("rr_tx_done", 32'(tx_ok_cnt - base), 32'd1);
    wr_obs.delete();

    // Reset in the middle of a transaction
    for (int i = 0; i < 100 && !uart_busy; i++) tick();
    check("busy_seen", 32'(uart_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {29'd0, uart_rd_en, uart_wr_en, init_done}, 32'd0);
    check("rst_mid_tx_ready", 32'(tx_ready), 32'd0);
    wr_obs.delete();
    wr_exp.push_back('{addr: 5'h0C, data: 32'h0000_0001});
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 100 && wr_obs.size() < 1; i++) tick();
    drain_writes("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
